traffic_req_sync: RTL and testbench



---
 rtl/traffic_pkg.sv | 15 +
 rtl/traffic_debounce.sv | 30 +++
 rtl/traffic_req_sync.sv | 83 ++++++++
 tb/tb_traffic_req_sync.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: request indices, lamp encodings and request states shared with the controller
package traffic_pkg;
   localparam int N_REQ  = 5;
   localparam int IDX_P1 = 0;
   localparam int IDX_P2 = 1;
   localparam int IDX_P3 = 2;
   localparam int IDX_P4 = 3;
   localparam int IDX_PL = 4;
   localparam logic [4:0] GREEN    = 5'b10011;
   localparam logic [4:0] YELLOW   = 5'b01000;
   localparam logic [4:0] RED      = 5'b00100;
   localparam logic [3:0] PL_GREEN = 4'b0000;
   localparam logic [3:0] PL_RED   = 4'b1111;
   typedef enum logic {IDLE, PENDING} req_state_t;
endpackage

// File: rtl/traffic_debounce.sv
// traffic_debounce: two-flop synchroniser and tick-sampled debounce for one detector input
module traffic_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   output logic clean
);
   localparam int CW = $clog2(DEB_CYCLES);
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= '0;
         cnt   <= '0;
         clean <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (tick) begin
            if (sync[1] == clean) cnt <= '0;
            else if (cnt == CW'(DEB_CYCLES - 1)) begin
               cnt   <= '0;
               clean <= ~clean;
            end else cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/traffic_req_sync.sv
// traffic_req_sync: debounced, latched service requests feeding the traffic light controller
// Define TRAFFIC_REQ_AGE_EN to build per-request age counters that drive req_urgent.
module traffic_req_sync
   import traffic_pkg::*;
#(
   parameter int SAMPLE_DIV = 1000,
   parameter int DEB_CYCLES = 16,
   parameter int MAX_WAIT   = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] sense_in,
   input  logic [N_REQ-1:0] serve_ack,
   output logic [N_REQ-1:0] sense_clean,
   output logic [N_REQ-1:0] req_pending,
   output logic [N_REQ-1:0] req_new,
   output logic [N_REQ-1:0] req_urgent
);
   localparam int PW = $clog2(SAMPLE_DIV);
   logic [PW-1:0]    pre;
   logic             tick;
   logic [N_REQ-1:0] clean_q, rise;
   req_state_t       state [N_REQ];
   req_state_t       state_nx [N_REQ];
   assign tick = pre == PW'(SAMPLE_DIV - 1);
   assign rise = sense_clean & ~clean_q;
   always_ff @(posedge clk) begin
      if (reset) pre <= '0;
      else pre <= tick ? '0 : pre + 1'b1;
   end
   for (genvar i = 0; i < N_REQ; i++) begin : g_deb
      traffic_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .raw   (sense_in[i]),
         .clean (sense_clean[i])
      );
   end
   // A new rising edge outranks a coincident ack so fresh demand is never dropped.
   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         state_nx[i] = rise[i] ? PENDING : serve_ack[i] ? IDLE : state[i];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         clean_q <= '0;
         req_new <= '0;
         for (int i = 0; i < N_REQ; i++) state[i] <= IDLE;
      end else begin
         clean_q <= sense_clean;
         for (int i = 0; i < N_REQ; i++) begin
            state[i]   <= state_nx[i];
            req_new[i] <= rise[i] && state[i] == IDLE;
         end
      end
   end
   always_comb begin
      req_pending = '0;
      for (int i = 0; i < N_REQ; i++) req_pending[i] = state[i] == PENDING;
   end
`ifdef TRAFFIC_REQ_AGE_EN
   // Sized to hold MAX_WAIT itself so the saturated value never wraps.
   localparam int AW = $clog2(MAX_WAIT + 1);
   logic [AW-1:0] age [N_REQ];
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (reset || state_nx[i] == IDLE || (rise[i] && (state[i] == IDLE || serve_ack[i])))
            age[i] <= '0;
         else if (tick && age[i] != AW'(MAX_WAIT))
            age[i] <= age[i] + 1'b1;
      end
   end
   always_comb begin
      req_urgent = '0;
      for (int i = 0; i < N_REQ; i++)
         req_urgent[i] = state[i] == PENDING && age[i] == AW'(MAX_WAIT);
   end
`else
   localparam int unused_max_wait = MAX_WAIT;
   assign req_urgent = '0;
`endif
endmodule

// File: tb/tb_traffic_req_sync.sv
// tb_traffic_req_sync: directed vectors and corner sequences for traffic_req_sync
module tb_traffic_req_sync;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] sense_in = '0;
   logic [4:0] serve_ack = '0;
   logic [4:0] sense_clean, req_pending, req_new, req_urgent;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         lat;
   typedef struct {
      logic [4:0] sense;
      logic [4:0] ack;
      logic [4:0] clean;
      logic [4:0] pend;
      logic [4:0] nw;
   } vec_t;
   vec_t vec [17];
`ifdef TRAFFIC_REQ_AGE_EN
   localparam logic [4:0] URG2 = 5'b00100;
`else
   localparam logic [4:0] URG2 = 5'b00000;
`endif
   always #5 clk = ~clk;
   traffic_req_sync #(.SAMPLE_DIV(4), .DEB_CYCLES(3), .MAX_WAIT(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .sense_in    (sense_in),
      .serve_ack   (serve_ack),
      .sense_clean (sense_clean),
      .req_pending (req_pending),
      .req_new     (req_new),
      .req_urgent  (req_urgent)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d cycles want %0d..%0d", name, act, lo, hi);
      end
   endtask
   task automatic wait_clean(input int b, input logic v, output int n);
      n = 0;
      while (sense_clean[b] !== v && n < 30) begin
         step();
         n++;
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      // clean press on P1 straight out of reset, then ack while pending and ack while idle
      for (int i = 0; i < 11; i++) vec[i] = '{5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      vec[11] = '{5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00000};
      vec[12] = '{5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00001};
      vec[13] = '{5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000};
      vec[14] = '{5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
      vec[15] = '{5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
      vec[16] = '{5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00000};
      reset = 1'b1;
      sense_in = 5'b11111;
      repeat (3) begin
         step();
         chk("reset_outputs", sense_clean | req_pending | req_new | req_urgent, 5'b00000);
      end
      reset = 1'b0;
      for (int i = 0; i < 17; i++) begin
         sense_in = vec[i].sense;
         serve_ack = vec[i].ack;
         step();
         chk($sformatf("vec%0d_clean", i), sense_clean, vec[i].clean);
         chk($sformatf("vec%0d_pend", i), req_pending, vec[i].pend);
         chk($sformatf("vec%0d_new", i), req_new, vec[i].nw);
         chk($sformatf("vec%0d_urgent", i), req_urgent, 5'b00000);
      end
      serve_ack = '0;
      // P2: press, release, press again with an ack landing on the new rising edge
      sense_in = 5'b00011;
      wait_clean(1, 1'b1, lat);
      chk_range("p2_rise_latency", lat, 11, 14);
      step();
      chk("p2_pend", req_pending, 5'b00010);
      chk("p2_new", req_new, 5'b00010);
      step();
      chk("p2_new_single", req_new, 5'b00000);
      sense_in = 5'b00001;
      wait_clean(1, 1'b0, lat);
      chk_range("p2_fall_latency", lat, 11, 14);
      chk("p2_hold_after_release", req_pending, 5'b00010);
      sense_in = 5'b00011;
      wait_clean(1, 1'b1, lat);
      chk_range("p2_rerise_latency", lat, 11, 14);
      serve_ack = 5'b00010;
      step();
      serve_ack = '0;
      chk("ack_vs_rise_pend", req_pending, 5'b00010);
      chk("ack_vs_rise_new", req_new, 5'b00000);
      serve_ack = 5'b00010;
      step();
      serve_ack = '0;
      chk("p2_ack_clear", req_pending, 5'b00000);
      // PL bounce: at most two consecutive high samples, never qualifies
      for (int c = 0; c < 60; c++) begin
         sense_in[4] = (c % 12) < 8;
         step();
         chk("pl_bounce", {sense_clean[4], req_pending[4], req_new[4], 2'b00}, 5'b00000);
      end
      sense_in[4] = 1'b0;
      // P3 left pending: urgent after 5 ticks, saturates, clears with the ack
      sense_in = 5'b00101;
      wait_clean(2, 1'b1, lat);
      chk_range("p3_rise_latency", lat, 11, 14);
      step();
      chk("p3_pend", req_pending, 5'b00100);
      repeat (18) begin
         step();
         chk("p3_not_urgent_yet", req_urgent, 5'b00000);
      end
      step();
      chk("p3_urgent", req_urgent, URG2);
      repeat (12) step();
      chk("p3_urgent_saturated", req_urgent, URG2);
      serve_ack = 5'b00100;
      step();
      serve_ack = '0;
      chk("p3_ack_urgent", req_urgent, 5'b00000);
      chk("p3_ack_pend", req_pending, 5'b00000);
      // P4: reset after two qualifying ticks discards the partial count
      reset = 1'b1;
      sense_in = 5'b00000;
      repeat (2) step();
      chk("reset2_outputs", sense_clean | req_pending | req_new | req_urgent, 5'b00000);
      reset = 1'b0;
      sense_in = 5'b01000;
      repeat (9) step();
      chk("p4_partial", sense_clean, 5'b00000);
      reset = 1'b1;
      repeat (2) step();
      chk("reset3_outputs", sense_clean | req_pending | req_new | req_urgent, 5'b00000);
      reset = 1'b0;
      wait_clean(3, 1'b1, lat);
      chk_range("p4_requalify_latency", lat, 12, 12);
      step();
      chk("p4_pend", req_pending, 5'b01000);
      chk("p4_new", req_new, 5'b01000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
